ddr4_rd_lane_align: RTL and testbench

- Fabric-side receive aligner for one DDR4 read-data lane.
- Sits behind an input-direction IOD, the counterpart of the output/ODT IODs. Consumes its deserialized RX_DATA and trains word alignment by pulsing RX_BIT_SLIP and stepping the dynamic delay line against a known read-training pattern.
- After training, forwards registered, aligned read words to the DDR controller datapath.

---
 rtl/ddr4_rd_align_pkg.sv | 22 ++
 rtl/ddr4_rd_pattern_match.sv | 48 ++++
 rtl/ddr4_rd_lane_align.sv | 192 +++++++++++++++++++
 tb/tb_ddr4_rd_lane_align.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr4_rd_align_pkg.sv
// rtl/ddr4_rd_align_pkg.sv - shared FSM states, default training word and counter width helper
package ddr4_rd_align_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        CHECK,
        SLIP,
        MOVE,
        DONE,
        FAIL
    } state_t;

    localparam logic [7:0] DEF_TRAIN_PATTERN = 8'b0000_1111;

    // Bits needed for a counter that must be able to hold max_val itself.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ddr4_rd_pattern_match.sv
// rtl/ddr4_rd_pattern_match.sv - training-word compare with match-run and check-window counters
module ddr4_rd_pattern_match
    import ddr4_rd_align_pkg::*;
#(
    parameter int            DW        = 8,
    parameter logic [DW-1:0] PATTERN   = DW'(DEF_TRAIN_PATTERN),
    parameter int            MATCH_CNT = 4,
    parameter int            CHECK_WIN = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] data,
    output logic          lock,
    output logic          expire
);

    localparam int RW = cnt_w(MATCH_CNT);
    localparam int WW = cnt_w(CHECK_WIN);

    logic [RW-1:0] run_q, run_d;
    logic [WW-1:0] win_q, win_d;
    logic          hit;

    // Both counters restart from zero whenever a new check window opens.
    always_comb begin
        hit   = (data == PATTERN);
        run_d = '0;
        win_d = '0;
        if (en) begin
            run_d = hit ? run_q + 1'b1 : '0;
            win_d = win_q + 1'b1;
        end
        lock   = en && hit && (run_q == RW'(MATCH_CNT - 1));
        expire = en && (win_q == WW'(CHECK_WIN - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= '0;
            win_q <= '0;
        end else begin
            run_q <= run_d;
            win_q <= win_d;
        end
    end

endmodule

// File: rtl/ddr4_rd_lane_align.sv
// rtl/ddr4_rd_lane_align.sv - DDR4 read-lane word aligner; DDR4_RD_ALIGN_ERRCNT_EN adds the post-lock error monitor
module ddr4_rd_lane_align
    import ddr4_rd_align_pkg::*;
#(
    parameter int            DW            = 8,
    parameter logic [DW-1:0] TRAIN_PATTERN = DW'(DEF_TRAIN_PATTERN),
    parameter int            MATCH_CNT     = 4,
    parameter int            CHECK_WIN     = 16,
    parameter int            SETTLE_CYC    = 3,
    parameter int            MAX_DLY_STEPS = 64
) (
    input  logic                               FAB_CLK,
    input  logic                               RX_SYNC_RST,
    input  logic                               TRAIN_START,
    input  logic [DW-1:0]                      RX_DATA,
    input  logic                               DELAY_LINE_OUT_OF_RANGE,
    input  logic                               RD_EN,
    output logic                               RX_BIT_SLIP,
    output logic                               DELAY_LINE_LOAD,
    output logic                               DELAY_LINE_MOVE,
    output logic                               DELAY_LINE_DIRECTION,
    output logic                               TRAIN_DONE,
    output logic                               TRAIN_FAIL,
    output logic [$clog2(DW)-1:0]              SLIP_POS,
    output logic [$clog2(MAX_DLY_STEPS):0]     DLY_TAPS,
    output logic [DW-1:0]                      RD_DATA,
    output logic                               RD_VALID
`ifdef DDR4_RD_ALIGN_ERRCNT_EN
    ,
    input  logic                               MON_EN,
    output logic [15:0]                        ERR_CNT
`endif
);

    localparam int SW  = $clog2(DW);
    localparam int TW  = $clog2(MAX_DLY_STEPS) + 1;
    localparam int STW = cnt_w(SETTLE_CYC);

    state_t         state_q, state_d;
    logic [STW-1:0] settle_q, settle_d;
    logic [SW-1:0]  tries_q, tries_d;
    logic [SW-1:0]  slip_pos_q, slip_pos_d;
    logic [TW-1:0]  taps_q, taps_d;
    logic           slip_pulse_q, slip_pulse_d;
    logic           load_pulse_q, load_pulse_d;
    logic           move_pulse_q, move_pulse_d;
    logic           dir_q, dir_d;
    logic           done_q, done_d;
    logic           fail_q, fail_d;
    logic [DW-1:0]  rd_data_q, rd_data_d;
    logic           rd_valid_q, rd_valid_d;
    logic           in_train;
    logic           lock;
    logic           expire;

    ddr4_rd_pattern_match #(
        .DW        (DW),
        .PATTERN   (TRAIN_PATTERN),
        .MATCH_CNT (MATCH_CNT),
        .CHECK_WIN (CHECK_WIN)
    ) u_match (
        .clk    (FAB_CLK),
        .rst    (RX_SYNC_RST),
        .en     (state_q == CHECK),
        .data   (RX_DATA),
        .lock   (lock),
        .expire (expire)
    );

    always_comb begin
        in_train = state_q inside {LOAD, SETTLE, CHECK, SLIP, MOVE};
        state_d  = state_q;
        case (state_q)
            IDLE:       if (TRAIN_START) state_d = LOAD;
            LOAD:       state_d = SETTLE;
            SETTLE:     if (settle_q == STW'(SETTLE_CYC - 1)) state_d = CHECK;
            CHECK: begin
                // Lock is tested first so a final matching word in the window still wins.
                if (lock) begin
                    state_d = DONE;
                end else if (expire) begin
                    if (tries_q < SW'(DW - 1))
                        state_d = SLIP;
                    else if (taps_q < TW'(MAX_DLY_STEPS))
                        state_d = MOVE;
                    else
                        state_d = FAIL;
                end
            end
            SLIP, MOVE: state_d = SETTLE;
            DONE, FAIL: if (TRAIN_START) state_d = LOAD;
            default:    state_d = IDLE;
        endcase
        if (in_train && DELAY_LINE_OUT_OF_RANGE) state_d = FAIL;

        settle_d   = (state_q == SETTLE) ? settle_q + 1'b1 : '0;
        slip_pos_d = slip_pos_q;
        tries_d    = tries_q;
        taps_d     = taps_q;
        case (state_d)
            LOAD: begin
                slip_pos_d = '0;
                tries_d    = '0;
                taps_d     = '0;
            end
            SLIP: begin
                slip_pos_d = (slip_pos_q == SW'(DW - 1)) ? '0 : slip_pos_q + 1'b1;
                tries_d    = tries_q + 1'b1;
            end
            // The IOD keeps its slip state across a tap move, so SLIP_POS carries on.
            MOVE: begin
                taps_d  = taps_q + 1'b1;
                tries_d = '0;
            end
            default: ;
        endcase

        load_pulse_d = (state_d == LOAD);
        slip_pulse_d = (state_d == SLIP);
        move_pulse_d = (state_d == MOVE);
        dir_d        = state_d inside {LOAD, SETTLE, CHECK, SLIP, MOVE};
        done_d       = (state_d == DONE);
        fail_d       = (state_d == FAIL);
        rd_data_d    = RX_DATA;
        rd_valid_d   = RD_EN && done_q && (state_d == DONE);
    end

    always_ff @(posedge FAB_CLK) begin
        if (RX_SYNC_RST) begin
            state_q      <= IDLE;
            settle_q     <= '0;
            tries_q      <= '0;
            slip_pos_q   <= '0;
            taps_q       <= '0;
            slip_pulse_q <= 1'b0;
            load_pulse_q <= 1'b0;
            move_pulse_q <= 1'b0;
            dir_q        <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            tries_q      <= tries_d;
            slip_pos_q   <= slip_pos_d;
            taps_q       <= taps_d;
            slip_pulse_q <= slip_pulse_d;
            load_pulse_q <= load_pulse_d;
            move_pulse_q <= move_pulse_d;
            dir_q        <= dir_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    assign RX_BIT_SLIP          = slip_pulse_q;
    assign DELAY_LINE_LOAD      = load_pulse_q;
    assign DELAY_LINE_MOVE      = move_pulse_q;
    assign DELAY_LINE_DIRECTION = dir_q;
    assign TRAIN_DONE           = done_q;
    assign TRAIN_FAIL           = fail_q;
    assign SLIP_POS             = slip_pos_q;
    assign DLY_TAPS             = taps_q;
    assign RD_DATA              = rd_data_q;
    assign RD_VALID             = rd_valid_q;

`ifdef DDR4_RD_ALIGN_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (state_d == LOAD)
            err_cnt_d = '0;
        else if (state_q == DONE && MON_EN && RX_DATA != TRAIN_PATTERN && err_cnt_q != 16'hFFFF)
            err_cnt_d = err_cnt_q + 1'b1;
    end

    always_ff @(posedge FAB_CLK) begin
        if (RX_SYNC_RST)
            err_cnt_q <= '0;
        else
            err_cnt_q <= err_cnt_d;
    end

    assign ERR_CNT = err_cnt_q;
`endif

endmodule

// File: tb/tb_ddr4_rd_lane_align.sv
// tb/tb_ddr4_rd_lane_align.sv - scoreboard bench for ddr4_rd_lane_align against an IOD and training-sequence model
module tb_ddr4_rd_lane_align;

    localparam int         MATCH_CNT  = 4;
    localparam int         CHECK_WIN  = 16;
    localparam int         SETTLE_CYC = 3;
    localparam int         MAX_DLY    = 64;
    localparam logic [7:0] PAT        = 8'h0F;

    localparam int K_LOAD = 0;
    localparam int K_SLIP = 1;
    localparam int K_MOVE = 2;
    localparam int K_DONE = 3;
    localparam int K_FAIL = 4;

    typedef struct {
        int kind;
        int rel;
        int slip;
        int taps;
        int dir;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       train_start;
    logic [7:0] rx_data;
    logic       oor;
    logic       rd_en;
    logic       rx_bit_slip;
    logic       dl_load;
    logic       dl_move;
    logic       dl_dir;
    logic       train_done;
    logic       train_fail;
    logic [2:0] slip_pos;
    logic [6:0] dly_taps;
    logic [7:0] rd_data;
    logic       rd_valid;
`ifdef DDR4_RD_ALIGN_ERRCNT_EN
    logic        mon_en;
    logic [15:0] err_cnt;
`endif

    int         cyc = 0;
    int         start_cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    int         good_slip = 0;
    int         good_tap = 0;
    int         iod_slip;
    int         iod_taps;
    logic       iod_en;
    logic [7:0] iod_word;
    logic [7:0] tb_word;
    ev_t        exp_q[$];
    logic [7:0] rd_q[$];

    assign rx_data = iod_en ? iod_word : tb_word;

    ddr4_rd_lane_align dut (
        .FAB_CLK                 (clk),
        .RX_SYNC_RST             (rst),
        .TRAIN_START             (train_start),
        .RX_DATA                 (rx_data),
        .DELAY_LINE_OUT_OF_RANGE (oor),
        .RD_EN                   (rd_en),
        .RX_BIT_SLIP             (rx_bit_slip),
        .DELAY_LINE_LOAD         (dl_load),
        .DELAY_LINE_MOVE         (dl_move),
        .DELAY_LINE_DIRECTION    (dl_dir),
        .TRAIN_DONE              (train_done),
        .TRAIN_FAIL              (train_fail),
        .SLIP_POS                (slip_pos),
        .DLY_TAPS                (dly_taps),
        .RD_DATA                 (rd_data),
        .RD_VALID                (rd_valid)
`ifdef DDR4_RD_ALIGN_ERRCNT_EN
        ,
        .MON_EN                  (mon_en),
        .ERR_CNT                 (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [7:0] rotl(input logic [7:0] v, input int r);
        return (v << r) | (v >> (8 - r));
    endfunction

    function automatic logic [63:0] outs();
        return {39'd0, rx_bit_slip, dl_load, dl_move, dl_dir, train_done, train_fail,
                slip_pos, dly_taps, rd_data, rd_valid};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic push_ev(input int kind, input int rel, input int slip, input int taps, input int dir);
        ev_t e;
        e.kind = kind;
        e.rel  = rel;
        e.slip = slip;
        e.taps = taps;
        e.dir  = dir;
        exp_q.push_back(e);
    endtask

    // Expected training sequence relative to the cycle TRAIN_START is driven:
    // LOAD one cycle later, then per position SETTLE_CYC settle cycles and a check
    // window that either locks after MATCH_CNT words or ends in a slip/move/fail.
    task automatic model_training(input int gs, input int gt);
        int  t, c, p, slip, taps, tries;
        bit  fin;
        push_ev(K_LOAD, 1, 0, 0, 1);
        t = 1; slip = 0; taps = 0; tries = 0; fin = 0;
        while (!fin) begin
            c = t + 1;
            if (taps >= gt && slip == gs) begin
                push_ev(K_DONE, c + SETTLE_CYC + MATCH_CNT, slip, taps, -1);
                fin = 1;
            end else begin
                p = c + SETTLE_CYC + CHECK_WIN;
                if (tries < 7) begin
                    slip = (slip + 1) % 8;
                    tries++;
                    push_ev(K_SLIP, p, slip, taps, 1);
                end else if (taps < MAX_DLY) begin
                    taps++;
                    tries = 0;
                    push_ev(K_MOVE, p, slip, taps, 1);
                end else begin
                    push_ev(K_FAIL, p, slip, taps, -1);
                    fin = 1;
                end
                t = p;
            end
        end
    endtask

    task automatic take(input int kind);
        ev_t e;
        int  d, rel;
        rel = cyc - start_cyc;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got kind=%0d at rel %0d, want no event", kind, rel);
        end else begin
            e = exp_q.pop_front();
            d = (e.dir < 0) ? -1 : int'(dl_dir);
            if (kind != e.kind || rel != e.rel || int'(slip_pos) != e.slip ||
                int'(dly_taps) != e.taps || d != e.dir) begin
                n_err++;
                $display("FAIL event: got kind=%0d rel=%0d slip=%0d taps=%0d dir=%0d, want kind=%0d rel=%0d slip=%0d taps=%0d dir=%0d",
                         kind, rel, slip_pos, dly_taps, d, e.kind, e.rel, e.slip, e.taps, e.dir);
            end
        end
    endtask

    // IOD model: tracks slips and taps from the DUT pulses and presents the
    // training word rotated by the remaining misalignment.
    initial begin
        int rot;
        iod_slip = 0;
        iod_taps = 0;
        iod_word = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                iod_slip = 0;
                iod_taps = 0;
            end else begin
                if (dl_load) begin
                    iod_slip = 0;
                    iod_taps = 0;
                end
                if (rx_bit_slip) iod_slip = (iod_slip + 1) % 8;
                if (dl_move && dl_dir) iod_taps++;
            end
            rot = (good_slip - iod_slip) & 7;
            if (rot == 0 && iod_taps < good_tap) rot = $urandom_range(1, 7);
            iod_word = (rot == 0) ? PAT : rotl(PAT, rot);
        end
    end

    initial begin
        logic pd, pf;
        logic [7:0] w;
        pd = 1'b0;
        pf = 1'b0;
        forever begin
            @(negedge clk);
            if (dl_load)                take(K_LOAD);
            if (rx_bit_slip)            take(K_SLIP);
            if (dl_move)                take(K_MOVE);
            if (train_done && !pd)      take(K_DONE);
            if (train_fail && !pf)      take(K_FAIL);
            pd = train_done;
            pf = train_fail;
            if (rd_valid) begin
                n_cmp++;
                if (rd_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rd_valid_unexpected: got RD_VALID=1 data=%0h, want RD_VALID=0", rd_data);
                end else begin
                    w = rd_q.pop_front();
                    if (rd_data !== w) begin
                        n_err++;
                        $display("FAIL rd_data: got %0h, want %0h", rd_data, w);
                    end
                end
            end
        end
    end

    task automatic pulse_start();
        train_start = 1'b1;
        start_cyc   = cyc;
        @(negedge clk);
        train_start = 1'b0;
    endtask

    task automatic wait_rel(input int r);
        while (cyc - start_cyc < r) @(negedge clk);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rd_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (exp_q.size() != 0 || rd_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_timeout: got %0d events and %0d words outstanding, want 0", name, exp_q.size(), rd_q.size());
            exp_q.delete();
            rd_q.delete();
        end
    endtask

    initial begin
        logic [7:0] words[4];
        words[0] = 8'hA1; words[1] = 8'hB2; words[2] = 8'hC3; words[3] = 8'hD4;
        rst = 1'b1; train_start = 1'b0; oor = 1'b0; rd_en = 1'b0;
        iod_en = 1'b1; tb_word = 8'h00;
`ifdef DDR4_RD_ALIGN_ERRCNT_EN
        mon_en = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_outputs", outs(), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        good_slip = 0; good_tap = 0;
        model_training(0, 0);
        pulse_start();
        wait_drain("aligned_lock", 500);

        iod_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tb_word = words[i];
            rd_en   = 1'b1;
            rd_q.push_back(words[i]);
            @(negedge clk);
        end
        for (int i = 0; i < 20; i++) begin
            tb_word = 8'($urandom);
            rd_en   = 1'($urandom_range(0, 1));
            if (rd_en) rd_q.push_back(tb_word);
            @(negedge clk);
        end
        rd_en = 1'b0;
        wait_drain("read_path", 50);
        iod_en = 1'b1;

        good_slip = 3; good_tap = 0;
        model_training(3, 0);
        rd_en = 1'b1;
        pulse_start();
        check("done_cleared_on_restart", {63'd0, train_done}, 64'd0);
        for (int r = 1; r <= 8; r++) begin
            check("rd_valid_in_training", {63'd0, rd_valid}, 64'd0);
            @(negedge clk);
        end
        rd_en = 1'b0;
        wait_rel(12);
        train_start = 1'b1;
        @(negedge clk);
        train_start = 1'b0;
        wait_drain("slip3", 1000);

        good_slip = 3; good_tap = 5;
        model_training(3, 5);
        pulse_start();
        wait_drain("tap5", 2000);

        for (int k = 0; k < 3; k++) begin
            good_slip = $urandom_range(0, 7);
            good_tap  = $urandom_range(0, 1);
            model_training(good_slip, good_tap);
            pulse_start();
            wait_drain("random_lock", 1000);
        end

        good_slip = 0; good_tap = 1000;
        push_ev(K_LOAD, 1, 0, 0, 1);
        push_ev(K_FAIL, 7, 0, 0, -1);
        pulse_start();
        wait_rel(6);
        oor = 1'b1;
        @(negedge clk);
        oor = 1'b0;
        wait_drain("out_of_range", 50);
        repeat (30) @(negedge clk);
        check("oor_fail_held", {63'd0, train_fail}, 64'd1);

        push_ev(K_LOAD, 1, 0, 0, 1);
        pulse_start();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_mid_settle", outs(), 64'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("idle_after_reset", {61'd0, train_done, train_fail, dl_dir}, 64'd0);
        wait_drain("reset_abort", 5);

        good_slip = 0; good_tap = 1000;
        model_training(0, 1000);
        pulse_start();
        wait_drain("exhausted", 15000);
        repeat (40) @(negedge clk);
        check("exhausted_fail_held", {63'd0, train_fail}, 64'd1);
        check("exhausted_taps", {57'd0, dly_taps}, 64'd64);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
